// File: rtl/dmem_map_pkg.sv
// dmem_map_pkg: shared definitions for the data-side responder.
//   - MMIO register offsets (low address byte within the MMIO window)
//   - store-size encodings carried on the core's mask port
//   - STATUS register bit positions
//   - UART transmitter state encoding
//   - helpers that classify a store by size and low address bits
package dmem_map_pkg;

  localparam logic [7:0] OFF_LED       = 8'h00;
  localparam logic [7:0] OFF_CYCLE_LO  = 8'h04;
  localparam logic [7:0] OFF_CYCLE_HI  = 8'h08;
  localparam logic [7:0] OFF_UART_DATA = 8'h10;
  localparam logic [7:0] OFF_STATUS    = 8'h14;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;
  localparam logic [1:0] MASK_R = 2'b11;

  localparam int ST_BUSY     = 0;
  localparam int ST_DROP     = 1;
  localparam int ST_MISALIGN = 2;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // A store is legal when its low address bits are a multiple of its size.
  function automatic logic store_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      MASK_B:  ok = 1'b1;
      MASK_H:  ok = ~lo[0];
      MASK_W:  ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by an aligned store.
  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] lanes;
    case (size)
      MASK_B:  lanes = 4'b0001 << lo;
      MASK_H:  lanes = 4'b0011 << lo;
      MASK_W:  lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 LSB-first serial transmitter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : load request; honoured only while idle
//   data       : byte to send, captured with start
//   busy       : high whenever a frame is in progress
//   tx         : registered serial line, idles high
module uart_tx_core
  import dmem_map_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  // Next-state logic: every phase lasts BAUD_DIV cycles; tx changes on phase boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      UART_IDLE: begin
        if (start) begin
          state_d = UART_START;
          baud_d  = 16'd0;
          shift_d = data;
          tx_d    = 1'b0;
        end else begin
          tx_d    = 1'b1;
        end
      end
      UART_START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = UART_DATA;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d  = baud_q + 16'd1;
        end
      end
      UART_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      UART_STOP: begin
        if (baud_q == BAUD_LAST) begin
          state_d = UART_IDLE;
          baud_d  = 16'd0;
        end else begin
          baud_d  = baud_q + 16'd1;
        end
        tx_d = 1'b1;
      end
      default: begin
        state_d = UART_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State register; reset forces the line high immediately and drops any pending byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign busy = (state_q != UART_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder for the pipelined core.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   dmem_addr   : byte address; bit31 selects MMIO, else RAM (upper bits alias)
//   dmem_wdata  : right-aligned store data
//   mask        : store size (byte/half/word, 11 reserved)
//   dmem_wen    : active-low write strobe
//   dmem_rdata  : combinational aligned read word
//   led         : LED register
//   uart_tx     : serial output, idle high
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int RAM_WORDS = 4096,
  parameter int BAUD_DIV  = 434,
  parameter int LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_wdata,
  input  logic [1:0]       mask,
  input  logic             dmem_wen,
  output logic [31:0]      dmem_rdata,
  output logic [LED_W-1:0] led,
  output logic             uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]      ram_q [RAM_WORDS];
  logic [AW-1:0]    word_idx_s;
  logic             is_mmio_s, wr_s, aligned_s, ram_we_s;
  logic [7:0]       wr_off_s, rd_off_s;
  logic [3:0]       lanes_s;
  logic [31:0]      wshift_s, status_s;
  logic [LED_W-1:0] led_q, led_d;
  logic [63:0]      cycle_q, cycle_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             drop_q, drop_d, mis_q, mis_d;
  logic             drop_set_s, drop_clr_s, mis_set_s, mis_clr_s;
  logic             uart_start_s, uart_busy_s;
  logic             unused_s;

  assign is_mmio_s  = dmem_addr[31];
  assign word_idx_s = dmem_addr[AW+1:2];
  assign wr_s       = ~dmem_wen;
  assign wr_off_s   = dmem_addr[7:0];
  // Reads always return the whole aligned word, so decode ignores the byte offset.
  assign rd_off_s   = {dmem_addr[7:2], 2'b00};
  assign aligned_s  = store_aligned(mask, dmem_addr[1:0]);
  assign lanes_s    = store_lanes(mask, dmem_addr[1:0]);
  assign wshift_s   = dmem_wdata << {dmem_addr[1:0], 3'b000};
  assign unused_s   = ^dmem_addr;

  // Read mux: RAM word or MMIO register, zero for unmapped offsets.
  always_comb begin
    status_s              = 32'd0;
    status_s[ST_BUSY]     = uart_busy_s;
    status_s[ST_DROP]     = drop_q;
    status_s[ST_MISALIGN] = mis_q;
    dmem_rdata            = 32'd0;
    if (!is_mmio_s) begin
      dmem_rdata = ram_q[word_idx_s];
    end else begin
      case (rd_off_s)
        OFF_LED:      dmem_rdata = 32'(led_q);
        OFF_CYCLE_LO: dmem_rdata = cycle_q[31:0];
        OFF_CYCLE_HI: dmem_rdata = shadow_q;
        OFF_STATUS:   dmem_rdata = status_s;
        default:      dmem_rdata = 32'd0;
      endcase
    end
  end

  // Store decode: misaligned/reserved stores only raise MISALIGN.
  always_comb begin
    ram_we_s     = 1'b0;
    uart_start_s = 1'b0;
    led_d        = led_q;
    drop_set_s   = 1'b0;
    drop_clr_s   = 1'b0;
    mis_set_s    = 1'b0;
    mis_clr_s    = 1'b0;
    if (wr_s) begin
      if (!aligned_s) begin
        mis_set_s = 1'b1;
      end else if (!is_mmio_s) begin
        ram_we_s = 1'b1;
      end else begin
        case (wr_off_s)
          OFF_LED: begin
            if (mask == MASK_W) begin
              led_d = dmem_wdata[LED_W-1:0];
            end else begin
              led_d = led_q;
            end
          end
          OFF_UART_DATA: begin
            if (mask != MASK_B) begin
              uart_start_s = 1'b0;
            end else if (uart_busy_s) begin
              drop_set_s = 1'b1;
            end else begin
              uart_start_s = 1'b1;
            end
          end
          OFF_STATUS: begin
            drop_clr_s = dmem_wdata[ST_DROP];
            mis_clr_s  = dmem_wdata[ST_MISALIGN];
          end
          default: led_d = led_q;
        endcase
      end
    end else begin
      ram_we_s = 1'b0;
    end
  end

  // Counter, sticky flags (set beats clear) and the CYCLE_HI snapshot taken on any CYCLE_LO read.
  always_comb begin
    cycle_d = cycle_q + 64'd1;
    drop_d  = drop_set_s | (drop_q & ~drop_clr_s);
    mis_d   = mis_set_s | (mis_q & ~mis_clr_s);
    if (is_mmio_s && (rd_off_s == OFF_CYCLE_LO)) begin
      shadow_d = cycle_q[63:32];
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q    <= '0;
      cycle_q  <= 64'd0;
      shadow_q <= 32'd0;
      drop_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      shadow_q <= shadow_d;
      drop_q   <= drop_d;
      mis_q    <= mis_d;
    end
  end

  // RAM write port: only the selected byte lanes change; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_s[i]) begin
          ram_q[word_idx_s][8*i +: 8] <= wshift_s[8*i +: 8];
        end
      end
    end
  end

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .start (uart_start_s),
    .data  (dmem_wdata[7:0]),
    .busy  (uart_busy_s),
    .tx    (uart_tx)
  );

  assign led = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with a behavioural model of memory,
// MMIO registers and the serial line.
module tb_dmem_responder;

  localparam int RAM_WORDS = 4096;
  localparam int BAUD_DIV  = 4;
  localparam int LED_W     = 16;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_LO     = 32'h8000_0004;
  localparam logic [31:0] A_HI     = 32'h8000_0008;
  localparam logic [31:0] A_UART   = 32'h8000_0010;
  localparam logic [31:0] A_STATUS = 32'h8000_0014;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic [31:0]      dmem_addr  = 32'd0;
  logic [31:0]      dmem_wdata = 32'd0;
  logic [1:0]       mask       = 2'b10;
  logic             dmem_wen   = 1'b1;
  logic [31:0]      dmem_rdata;
  logic [LED_W-1:0] led;
  logic             uart_tx;

  int checks   = 0;
  int failures = 0;

  dmem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .BAUD_DIV  (BAUD_DIV),
    .LED_W     (LED_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .mask       (mask),
    .dmem_wen   (dmem_wen),
    .dmem_rdata (dmem_rdata),
    .led        (led),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0]      m_mem [int];
  logic [LED_W-1:0] m_led    = '0;
  logic [63:0]      m_cycle  = 64'd0;
  logic [31:0]      m_shadow = 32'd0;
  bit               m_drop   = 1'b0;
  bit               m_mis    = 1'b0;
  bit               m_busy   = 1'b0;
  bit               m_tx[$];

  logic [31:0] exp_q[$];
  string       exp_name_q[$];
  bit          rd_flag = 1'b0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // A frame is start bit, eight data bits LSB first, stop bit, each BAUD_DIV cycles.
  function automatic void push_frame(input logic [7:0] b);
    bit lvl[10];
    lvl[0] = 1'b0;
    for (int i = 0; i < 8; i++) lvl[i+1] = b[i];
    lvl[9] = 1'b1;
    for (int i = 0; i < 10; i++)
      for (int k = 0; k < BAUD_DIV; k++) m_tx.push_back(lvl[i]);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    int nb;
    int idx;
    int lo;
    logic [31:0] w;
    nb = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 0;
    lo = int'(a[1:0]);
    if (nb == 0 || (lo % nb) != 0) begin
      m_mis = 1'b1;
    end else if (a[31] == 1'b0) begin
      idx = int'(a[30:2]) % RAM_WORDS;
      w = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
      for (int b = 0; b < nb; b++) w[8*(lo+b) +: 8] = d[8*b +: 8];
      m_mem[idx] = w;
    end else begin
      case (a[7:0])
        8'h00: if (nb == 4) m_led = d[LED_W-1:0];
        8'h10: if (nb == 1) begin
                 if (m_busy) m_drop = 1'b1;
                 else push_frame(d[7:0]);
               end
        8'h14: begin
                 if (d[1]) m_drop = 1'b0;
                 if (d[2]) m_mis = 1'b0;
               end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    int idx;
    r = 32'd0;
    if (!a[31]) begin
      idx = int'(a[30:2]) % RAM_WORDS;
      if (m_mem.exists(idx)) r = m_mem[idx];
    end else begin
      case ({a[7:2], 2'b00})
        8'h00:   r = 32'(m_led);
        8'h04:   r = m_cycle[31:0];
        8'h08:   r = m_shadow;
        8'h14:   r = {29'd0, m_mis, m_drop, m_busy};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Model advance per clock, then per-cycle check of the serial line and LEDs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_led = '0; m_cycle = 64'd0; m_shadow = 32'd0;
      m_drop = 1'b0; m_mis = 1'b0; m_busy = 1'b0;
      m_tx.delete();
    end else begin
      bit exp_tx;
      if (dmem_addr[31] && dmem_addr[7:2] == 6'd1) m_shadow = m_cycle[63:32];
      if (!dmem_wen) model_store(dmem_addr, dmem_wdata, mask);
      m_cycle = m_cycle + 64'd1;
      #1;
      if (m_tx.size() > 0) begin
        exp_tx = m_tx.pop_front();
        m_busy = 1'b1;
      end else begin
        exp_tx = 1'b1;
        m_busy = 1'b0;
      end
      check("uart_tx", 64'(uart_tx), 64'(exp_tx));
      check("led", 64'(led), 64'(m_led));
    end
  end

  // Read monitor: compares dmem_rdata whenever a checked read is on the bus.
  always @(negedge clk) begin
    #2;
    if (rd_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_underflow: got read with no expectation at %0t", $time);
      end else begin
        check(exp_name_q.pop_front(), 64'(dmem_rdata), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic access(input logic [31:0] a, input bit wr, input logic [1:0] m,
                        input logic [31:0] d, input bit chk, input string nm);
    @(negedge clk);
    dmem_addr  = a;
    dmem_wdata = d;
    mask       = m;
    dmem_wen   = ~wr;
    if (chk) begin
      exp_q.push_back(model_read(a));
      exp_name_q.push_back(nm);
    end
    rd_flag = chk;
    @(posedge clk);
    #1;
    dmem_addr  = 32'd0;
    dmem_wdata = 32'd0;
    mask       = 2'b10;
    dmem_wen   = 1'b1;
    rd_flag    = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
    access(a, 1'b1, m, d, 1'b0, "");
  endtask

  task automatic rd(input logic [31:0] a, input string nm);
    access(a, 1'b0, 2'b10, 32'd0, 1'b1, nm);
  endtask

  // Returns positioned so the next access lands in the first idle cycle.
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (m_busy && n < 200);
    if (m_busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  m;

    repeat (3) @(posedge clk);
    #1;
    check("reset_uart_tx", 64'(uart_tx), 64'd1);
    check("reset_led", 64'(led), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_LED, "reset_led_reg");
    rd(A_STATUS, "reset_status");
    rd(A_HI, "reset_shadow");
    rd(A_LO, "cycle_lo_after_reset");

    // Word then byte merge, and same-cycle read
    wr(32'h100, 2'b10, 32'hDEAD_BEEF);
    wr(32'h102, 2'b00, 32'h0000_0055);
    rd(32'h100, "byte_merge");
    rd(32'h4100, "alias_read");

    // Read during write returns old data
    wr(32'h200, 2'b10, 32'h1111_1111);
    access(32'h200, 1'b1, 2'b10, 32'h2222_2222, 1'b1, "rdw_old");
    rd(32'h200, "rdw_new");

    // Half writes, misaligned half suppressed, W1C clear
    wr(32'h106, 2'b01, 32'h0000_1234);
    wr(32'h105, 2'b01, 32'h0000_FFFF);
    rd(32'h104, "half_upper");
    rd(A_STATUS, "misalign_set");
    wr(A_STATUS, 2'b10, 32'h4);
    rd(A_STATUS, "misalign_clr");
    wr(32'h108, 2'b11, 32'hFFFF_FFFF);
    rd(32'h108, "reserved_mask_nowrite");
    rd(A_STATUS, "reserved_mask_flag");
    wr(A_STATUS, 2'b10, 32'h6);

    // LED takes word stores only
    wr(A_LED, 2'b10, 32'hABCD_1234);
    wr(A_LED, 2'b00, 32'h0000_0077);
    rd(A_LED, "led_word_only");

    // Randomized RAM traffic with aliasing and illegal sizes
    for (int i = 0; i < 16; i++) wr(32'h300 + 32'(4*i), 2'b10, $urandom);
    for (int i = 0; i < 80; i++) begin
      a = 32'h300 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 7)) << 14);
      m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) wr(a, m, $urandom);
      else rd(a, "rand_rd");
    end
    rd(A_STATUS, "rand_status");
    wr(A_STATUS, 2'b10, 32'h6);

    // UART frame, dropped byte while busy, back-to-back frame
    wr(A_UART, 2'b00, 32'h0000_00A5);
    for (int i = 0; i < 6; i++) rd(A_STATUS, "busy_poll");
    wr(A_UART, 2'b00, 32'h0000_003C);
    rd(A_STATUS, "drop_set");
    wait_idle();
    wr(A_UART, 2'b00, 32'h0000_0069);
    rd(A_STATUS, "b2b_busy");
    wait_idle();
    rd(A_STATUS, "idle_drop_sticky");
    wr(A_STATUS, 2'b10, 32'h2);
    rd(A_STATUS, "drop_clr");

    // Counter wrap across the low word with snapshot
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
    m_cycle = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cycle_q;
    rd(A_LO, "cycle_lo_pre_wrap");
    rd(A_HI, "cycle_hi_snapshot");
    rd(A_LO, "cycle_lo_post_wrap");
    rd(A_HI, "cycle_hi_after_wrap");

    // Asynchronous reset in the middle of a data bit
    wr(A_LED, 2'b10, 32'h0000_5A5A);
    wr(A_UART, 2'b00, 32'h0000_0000);
    repeat (2*BAUD_DIV + 2) @(posedge clk);
    #3;
    check("pre_rst_uart_tx", 64'(uart_tx), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_uart_tx", 64'(uart_tx), 64'd1);
    check("async_rst_led", 64'(led), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_STATUS, "status_after_rst");
    rd(32'h100, "ram_kept_after_rst");
    rd(A_LO, "cycle_after_rst");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
